midi_tx: RTL and testbench

- MIDI serial transmitter. It is the outbound counterpart of the MIDI UART receiver already in the codebase.
- Accepts one MIDI message of 1–3 bytes per valid/ready handshake and serialises it onto the MIDI OUT line.
- Line format: 31250 baud, 8N1, LSB first, idle high.
- Byte packing matches the receiver's out_bytes: the first byte on the wire sits in [7:0], the second in [15:8], the third in [23:16].

---
 rtl/midi_tx.sv | 209 ++++++++++++++++++++
 tb/tb_midi_tx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_tx.sv
// midi_tx: MIDI OUT serial transmitter (31250 baud, 8N1, LSB first, idle high).
// Takes a 1..3 byte message per valid/ready handshake; byte0 is msg_bytes[7:0].
// Optional running-status compression is enabled by defining MIDI_TX_RUNNING_STATUS_EN.
module midi_tx #(
  parameter int unsigned CLKS_PER_BIT = 1600,
  parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [23:0] msg_bytes,
  input  logic [1:0]  msg_len,
  output logic        tx,
  output logic        tx_active,
  output logic        msg_done
);

  localparam int unsigned MSG_W = 24;
  localparam int unsigned LEN_W = 2;
  localparam int unsigned BIT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   last_idx_q, last_idx_d;
  logic [MSG_W-1:0]   bytes_q, bytes_d;
  logic               tx_q, tx_d;
  logic               ready_q, ready_d;
  logic               active_q, active_d;
  logic               done_q, done_d;

  logic               accept;
  logic               bit_end;
  logic [LEN_W-1:0]   eff_len;
  logic [MSG_W-1:0]   eff_bytes;
  logic [7:0]         cur_byte;

  assign accept  = msg_valid && ready_q;
  assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0] status_q, status_d;
  logic [7:0] byte0;
  logic       is_voice;
  logic       is_common;
  logic       skip;

  assign byte0     = msg_bytes[7:0];
  assign is_voice  = (byte0 >= 8'h80) && (byte0 <= 8'hEF);
  assign is_common = (byte0 >= 8'hF0) && (byte0 <= 8'hF7);
  assign skip      = (msg_len >= 2'd2) && is_voice && (byte0 == status_q);

  // Drop a repeated status byte and track the running status across messages
  always_comb begin
    status_d  = status_q;
    eff_len   = msg_len;
    eff_bytes = msg_bytes;
    if (skip) begin
      eff_len   = msg_len - 2'd1;
      eff_bytes = {8'h00, msg_bytes[23:8]};
    end
    if (accept && (msg_len != 2'd0)) begin
      if (is_voice) begin
        status_d = byte0;
      end else if (is_common) begin
        status_d = 8'h00;
      end
    end
  end

  // Running-status register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_q <= 8'h00;
    end else begin
      status_q <= status_d;
    end
  end
`else
  assign eff_len   = msg_len;
  assign eff_bytes = msg_bytes;
`endif

  // Byte currently being serialised
  always_comb begin
    cur_byte = bytes_q[7:0];
    case (idx_q)
      2'd0:    cur_byte = bytes_q[7:0];
      2'd1:    cur_byte = bytes_q[15:8];
      default: cur_byte = bytes_q[23:16];
    endcase
  end

  // Frame sequencer: next state and next registered outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    bytes_d    = bytes_q;
    tx_d       = tx_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          if (eff_len == 2'd0) begin
            done_d = 1'b1;
          end else begin
            state_d    = S_START;
            tx_d       = 1'b0;
            cnt_d      = '0;
            idx_d      = '0;
            last_idx_d = eff_len - 2'd1;
            bytes_d    = eff_bytes;
          end
        end
      end
      S_START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
          tx_d    = cur_byte[0];
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte[bit_q + 3'd1];
          end
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == last_idx_q) begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_START;
            tx_d    = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    ready_d  = (state_d == S_IDLE);
    active_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any frame in progress
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      idx_q      <= '0;
      last_idx_q <= '0;
      bytes_q    <= '0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      bytes_q    <= bytes_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  assign tx        = tx_q;
  assign msg_ready = ready_q;
  assign tx_active = active_q;
  assign msg_done  = done_q;

endmodule

// File: tb/tb_midi_tx.sv
// tb_midi_tx: directed self-checking bench for midi_tx with CLKS_PER_BIT=4.
// Cycle n=1 is the cycle right after the accepting clock edge; a frame of N bytes
// occupies n=1..40N and msg_done/msg_ready are high in cycle n=40N+1.
module tb_midi_tx;

  localparam int unsigned C = 4;

  logic        clk;
  logic        rst_n;
  logic        msg_valid;
  logic        msg_ready;
  logic [23:0] msg_bytes;
  logic [1:0]  msg_len;
  logic        tx;
  logic        tx_active;
  logic        msg_done;

  int n_cmp;
  int n_err;

  midi_tx #(.CLKS_PER_BIT(C)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .msg_bytes (msg_bytes),
    .msg_len   (msg_len),
    .tx        (tx),
    .tx_active (tx_active),
    .msg_done  (msg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level in cycle n of a frame carrying nbytes of b (byte0 first)
  function automatic logic exp_tx(input logic [23:0] b, input int nbytes, input int n);
    int p;
    int byt;
    int j;
    if (n < 1) return 1'b1;
    p   = (n - 1) / C;
    byt = p / 10;
    j   = p % 10;
    if (byt >= nbytes) return 1'b1;
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[byt*8 + j - 1];
  endfunction

  // Present a message and return just after the accepting edge
  task automatic send(input logic [23:0] b, input logic [1:0] len);
    int w;
    @(negedge clk);
    msg_valid = 1'b1;
    msg_bytes = b;
    msg_len   = len;
    w = 0;
    while (!msg_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (!msg_ready) begin
      n_err++;
      $display("FAIL send_ready: msg_ready=%b expected 1 within 2000 cycles", msg_ready);
    end
    @(posedge clk);
    #1 msg_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [3:0] got;
    rst_n     = 1'b0;
    msg_valid = 1'b0;
    msg_bytes = 24'h0;
    msg_len   = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = {tx, msg_ready, tx_active, msg_done};
    n_cmp++;
    if (got !== 4'b1100) begin
      n_err++;
      $display("FAIL reset_state: tx/rdy/act/done=%b expected 1100", got);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      got = {tx, msg_ready, tx_active, msg_done};
      n_cmp++;
      if (got !== 4'b1100) begin
        n_err++;
        $display("FAIL reset_idle cyc=%0d: tx/rdy/act/done=%b expected 1100", i, got);
      end
    end
  endtask

  task automatic test_three_byte;
    logic [3:0] got;
    logic [3:0] exp;
    int         l;
    l = 10 * 3 * C;
    send(24'h643C90, 2'd3);
    for (int n = 1; n <= l + 1; n++) begin
      @(negedge clk);
      got = {tx, msg_ready, tx_active, msg_done};
      exp = {exp_tx(24'h643C90, 3, n), n > l, n <= l, n == l + 1};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL three_byte n=%0d: tx/rdy/act/done=%b expected %b", n, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] got;
    logic [3:0] exp;
    int         l1;
    int         l2;
    l1 = 10 * 2 * C;
    l2 = 10 * 1 * C;
    send(24'h0005C0, 2'd2);
    // keep valid high with the second message queued behind the first
    msg_valid = 1'b1;
    msg_bytes = 24'h0000F8;
    msg_len   = 2'd1;
    for (int n = 1; n <= l1 + 1; n++) begin
      @(negedge clk);
      got = {tx, msg_ready, tx_active, msg_done};
      exp = {exp_tx(24'h0005C0, 2, n), n > l1, n <= l1, n == l1 + 1};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL b2b_first n=%0d: tx/rdy/act/done=%b expected %b", n, got, exp);
      end
    end
    @(posedge clk);
    #1 msg_valid = 1'b0;
    for (int n = 1; n <= l2 + 1; n++) begin
      @(negedge clk);
      got = {tx, msg_ready, tx_active, msg_done};
      exp = {exp_tx(24'h0000F8, 1, n), n > l2, n <= l2, n == l2 + 1};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL b2b_second n=%0d: tx/rdy/act/done=%b expected %b", n, got, exp);
      end
    end
  endtask

  task automatic test_len_zero;
    logic [3:0] got;
    send(24'h123456, 2'd0);
    @(negedge clk);
    got = {tx, msg_ready, tx_active, msg_done};
    n_cmp++;
    if (got !== 4'b1101) begin
      n_err++;
      $display("FAIL len0_done: tx/rdy/act/done=%b expected 1101", got);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      got = {tx, msg_ready, tx_active, msg_done};
      n_cmp++;
      if (got !== 4'b1100) begin
        n_err++;
        $display("FAIL len0_quiet cyc=%0d: tx/rdy/act/done=%b expected 1100", i, got);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [3:0] got;
    logic [3:0] exp;
    int         l;
    l = 10 * 3 * C;
    send(24'h7F4591, 2'd3);
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      got = {tx, msg_ready, tx_active, msg_done};
      exp = {exp_tx(24'h7F4591, 3, n), 1'b0, 1'b1, 1'b0};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL abort_pre n=%0d: tx/rdy/act/done=%b expected %b", n, got, exp);
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    got = {tx, msg_ready, tx_active, msg_done};
    n_cmp++;
    if (got !== 4'b1100) begin
      n_err++;
      $display("FAIL abort_reset: tx/rdy/act/done=%b expected 1100", got);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      got = {tx, msg_ready, tx_active, msg_done};
      n_cmp++;
      if (got !== 4'b1100) begin
        n_err++;
        $display("FAIL abort_quiet cyc=%0d: tx/rdy/act/done=%b expected 1100", i, got);
      end
    end
    send(24'h7F4591, 2'd3);
    for (int n = 1; n <= l + 1; n++) begin
      @(negedge clk);
      got = {tx, msg_ready, tx_active, msg_done};
      exp = {exp_tx(24'h7F4591, 3, n), n > l, n <= l, n == l + 1};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL abort_resend n=%0d: tx/rdy/act/done=%b expected %b", n, got, exp);
      end
    end
  endtask

  task automatic test_running_status;
    logic [23:0] in_b [6];
    logic [1:0]  in_l [6];
    logic [23:0] ex_b [6];
    int          ex_n [6];
    logic [3:0]  got;
    logic [3:0]  exp;
    int          l;
    in_b[0] = 24'h643C90; in_l[0] = 2'd3;
    in_b[1] = 24'h403E90; in_l[1] = 2'd3;
    in_b[2] = 24'h0000F8; in_l[2] = 2'd1;
    in_b[3] = 24'h003C90; in_l[3] = 2'd3;
    in_b[4] = 24'h0000F0; in_l[4] = 2'd1;
    in_b[5] = 24'h643C90; in_l[5] = 2'd3;
`ifdef MIDI_TX_RUNNING_STATUS_EN
    ex_b[0] = 24'h643C90; ex_n[0] = 3;
    ex_b[1] = 24'h00403E; ex_n[1] = 2;
    ex_b[2] = 24'h0000F8; ex_n[2] = 1;
    ex_b[3] = 24'h00003C; ex_n[3] = 2;
    ex_b[4] = 24'h0000F0; ex_n[4] = 1;
    ex_b[5] = 24'h643C90; ex_n[5] = 3;
`else
    for (int i = 0; i < 6; i++) begin
      ex_b[i] = in_b[i];
      ex_n[i] = int'(in_l[i]);
    end
`endif
    // start from a cleared running status
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int m = 0; m < 6; m++) begin
      l = 10 * ex_n[m] * C;
      send(in_b[m], in_l[m]);
      for (int n = 1; n <= l + 1; n++) begin
        @(negedge clk);
        got = {tx, msg_ready, tx_active, msg_done};
        exp = {exp_tx(ex_b[m], ex_n[m], n), n > l, n <= l, n == l + 1};
        n_cmp++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL rs_msg%0d n=%0d: tx/rdy/act/done=%b expected %b", m, n, got, exp);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_three_byte();
    test_back_to_back();
    test_len_zero();
    test_reset_mid_frame();
    test_running_status();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
